// File: rtl/jtopl_slot_ctrl_if.sv
// CPU parameter-write handshake between the register front end and the slot sequencer.
// The requester holds wr_req until wr_ack; wr_busy marks a pending request.
interface jtopl_slot_ctrl_if;
    logic       wr_req;
    logic [4:0] wr_slot;
    logic       wr_ack;
    logic       wr_busy;

    modport master (output wr_req, output wr_slot, input  wr_ack, input  wr_busy);
    modport slave  (input  wr_req, input  wr_slot, output wr_ack, output wr_busy);
endinterface

// File: rtl/jtopl_slot_ctrl.sv
// OPL slot sequencer: divides cen into cenop, walks the 18 operator slots and
// schedules CPU parameter writes into the slot time of their target operator.
module jtopl_slot_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    output logic       cenop,
    output logic [4:0] slot,
    output logic [1:0] group,
    output logic       op,
    output logic [1:0] subslot,
    output logic       zero,
    output logic       sample,
    jtopl_slot_ctrl_if.slave wr
);

    localparam logic [3:0] PRE_LAST  = 4'(DIV - 1);
    localparam logic [4:0] SLOT_LAST = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } wr_state_t;

    logic [3:0] pre;
    logic [4:0] next_slot;
    logic [4:0] tgt;
    wr_state_t  state, state_next;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (cen) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 4'd1;
        end
    end

    assign cenop     = cen && (pre == PRE_LAST);
    assign next_slot = (slot == SLOT_LAST) ? '0 : slot + 5'd1;
    assign sample    = cenop && (slot == SLOT_LAST);

    // Decode fields run as chained counters so they change on the same edge as slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot    <= '0;
            group   <= '0;
            op      <= 1'b0;
            subslot <= '0;
            zero    <= 1'b0;
        end else if (cenop) begin
            slot <= next_slot;
            zero <= (next_slot == SLOT_LAST);
            if (slot == SLOT_LAST) begin
                group   <= '0;
                op      <= 1'b0;
                subslot <= '0;
            end else if (group == 2'd2) begin
                group <= '0;
                op    <= ~op;
                if (op) subslot <= subslot + 2'd1;
            end else begin
                group <= group + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            tgt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && wr.wr_req) tgt <= wr.wr_slot;
        end
    end

    // The latch edge is never checked for a match, so a target entered on the
    // request edge waits a full frame. Targets above 17 never match.
    always_comb begin
        // NOTE: default first so no path through the block leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            ST_IDLE: if (wr.wr_req) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!wr.wr_req)
                    state_next = ST_IDLE;
                else if (cenop && next_slot == tgt)
                    state_next = ST_ACK;
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr.wr_ack  = (state == ST_ACK);
        wr.wr_busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_jtopl_slot_ctrl.sv
// Directed bench for jtopl_slot_ctrl: a DIV=4 instance on a continuous cen and
// a DIV=1 instance on a gapped cen, with hand-computed slot and write timing.
module tb_jtopl_slot_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b1;
    logic cen1 = 1'b0;

    int total = 0;
    int bad   = 0;

    logic       cenop, op, zero, sample;
    logic [4:0] slot;
    logic [1:0] group, subslot;
    logic       cenop1, op1, zero1, sample1;
    logic [4:0] slot1;
    logic [1:0] group1, subslot1;

    jtopl_slot_ctrl_if wb ();
    jtopl_slot_ctrl_if wb1 ();

    jtopl_slot_ctrl #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cenop(cenop), .slot(slot),
        .group(group), .op(op), .subslot(subslot), .zero(zero),
        .sample(sample), .wr(wb)
    );

    jtopl_slot_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .cen(cen1), .cenop(cenop1), .slot(slot1),
        .group(group1), .op(op1), .subslot(subslot1), .zero(zero1),
        .sample(sample1), .wr(wb1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for the negedge right after slot changes to s (prescaler then at 0).
    task automatic wait_entry(input logic [4:0] s);
        logic [4:0] prev;
        int n;
        bit ok;
        prev = slot;
        ok   = 1'b0;
        n    = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (slot == s && prev != s) ok = 1'b1;
            prev = slot;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_entry: slot %0d not entered within %0d clk", s, n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({cenop, slot, group, op, subslot, zero, sample, wb.wr_ack, wb.wr_busy} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {cenop, slot, group, op, subslot, zero, sample, wb.wr_ack, wb.wr_busy});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (slot !== 5'd0 || cenop !== 1'b1) begin
            bad++;
            $display("FAIL first_cenop: slot=%0d cenop=%b expected slot=0 cenop=1", slot, cenop);
        end
        @(negedge clk);
        total++;
        if (slot !== 5'd1 || cenop !== 1'b0) begin
            bad++;
            $display("FAIL first_advance: slot=%0d cenop=%b expected slot=1 cenop=0", slot, cenop);
        end
    endtask

    task automatic test_frame;
        int n_cenop;
        int n_sample;
        int e;
        n_cenop  = 0;
        n_sample = 0;
        wait_entry(5'd0);
        for (int i = 0; i < 72; i++) begin
            e = i / 4;
            if (cenop) n_cenop++;
            if (sample) n_sample++;
            total++;
            if (slot !== 5'(e) ||
                {group, op, subslot, zero} !== {2'(e % 3), 1'((e / 3) % 2), 2'(e / 6), (e == 17)}) begin
                bad++;
                $display("FAIL decode: slot=%0d g=%0d op=%0d ss=%0d z=%0d expected slot=%0d g=%0d op=%0d ss=%0d z=%0d",
                         slot, group, op, subslot, zero, e, e % 3, (e / 3) % 2, e / 6, e == 17);
            end
            if (i == 28) begin
                total++;
                if ({group, op, subslot, zero} !== {2'd1, 1'b0, 2'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL slot7_decode: g=%0d op=%0d ss=%0d z=%0d expected 1 0 1 0",
                             group, op, subslot, zero);
                end
            end
            if (i == 68) begin
                total++;
                if ({group, op, subslot, zero} !== {2'd2, 1'b1, 2'd2, 1'b1}) begin
                    bad++;
                    $display("FAIL slot17_decode: g=%0d op=%0d ss=%0d z=%0d expected 2 1 2 1",
                             group, op, subslot, zero);
                end
            end
            @(negedge clk);
        end
        total++;
        if (n_cenop !== 18 || n_sample !== 1) begin
            bad++;
            $display("FAIL frame_counts: cenop=%0d sample=%0d expected 18 and 1", n_cenop, n_sample);
        end
        total++;
        if (slot !== 5'd0) begin
            bad++;
            $display("FAIL frame_wrap: slot=%0d expected 0", slot);
        end
    endtask

    task automatic test_write;
        int n;
        bit busy_ok;
        wait_entry(5'd2);
        wb.wr_slot = 5'd5;
        wb.wr_req  = 1'b1;
        n       = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!wb.wr_busy) busy_ok = 1'b0;
        end while (!wb.wr_ack && n < 200);
        total++;
        if (n !== 12 || slot !== 5'd5 || !busy_ok) begin
            bad++;
            $display("FAIL write_latency: clk=%0d slot=%0d busy_ok=%b expected clk=12 slot=5 busy_ok=1",
                     n, slot, busy_ok);
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
        total++;
        if (wb.wr_ack !== 1'b0 || wb.wr_busy !== 1'b0) begin
            bad++;
            $display("FAIL write_single_pulse: ack=%b busy=%b expected 0 0", wb.wr_ack, wb.wr_busy);
        end
    endtask

    task automatic test_same_edge;
        int n;
        wait_entry(5'd6);
        repeat (3) @(negedge clk);
        total++;
        if (cenop !== 1'b1 || slot !== 5'd6) begin
            bad++;
            $display("FAIL same_edge_setup: cenop=%b slot=%0d expected 1 and 6", cenop, slot);
        end
        wb.wr_slot = 5'd7;
        wb.wr_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.wr_ack && n < 200);
        total++;
        if (n !== 73 || slot !== 5'd7) begin
            bad++;
            $display("FAIL same_edge_latency: clk=%0d slot=%0d expected clk=73 slot=7", n, slot);
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        wait_entry(5'd8);
        wb.wr_slot = 5'd10;
        wb.wr_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.wr_ack && n < 200);
        total++;
        if (n !== 8 || slot !== 5'd10) begin
            bad++;
            $display("FAIL b2b_first: clk=%0d slot=%0d expected clk=8 slot=10", n, slot);
        end
        wb.wr_slot = 5'd12;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                total++;
                if (wb.wr_ack !== 1'b0 || wb.wr_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_gap: ack=%b busy=%b expected 0 0", wb.wr_ack, wb.wr_busy);
                end
            end
            if (n == 2) begin
                total++;
                if (wb.wr_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_relatch: busy=%b expected 1", wb.wr_busy);
                end
            end
        end while (!wb.wr_ack && n < 200);
        total++;
        if (n !== 8 || slot !== 5'd12) begin
            bad++;
            $display("FAIL b2b_second: clk=%0d slot=%0d expected clk=8 slot=12", n, slot);
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop;
        int acks;
        wait_entry(5'd2);
        wb.wr_slot = 5'd15;
        wb.wr_req  = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (wb.wr_busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_busy: busy=%b expected 1", wb.wr_busy);
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
        total++;
        if (wb.wr_busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_release: busy=%b expected 0", wb.wr_busy);
        end
        acks = 0;
        repeat (80) begin
            @(negedge clk);
            if (wb.wr_ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL drop_no_ack: acks=%0d expected 0", acks);
        end
    endtask

    task automatic test_bad_slot;
        int acks;
        wb.wr_slot = 5'd20;
        wb.wr_req  = 1'b1;
        acks = 0;
        repeat (100) begin
            @(negedge clk);
            if (wb.wr_ack) acks++;
        end
        total++;
        if (acks !== 0 || wb.wr_busy !== 1'b1) begin
            bad++;
            $display("FAIL bad_slot: acks=%0d busy=%b expected 0 and 1", acks, wb.wr_busy);
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
        total++;
        if (wb.wr_busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_slot_release: busy=%b expected 0", wb.wr_busy);
        end
    endtask

    task automatic test_reset_mid_write;
        int acks;
        wait_entry(5'd9);
        wb.wr_slot = 5'd3;
        wb.wr_req  = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({cenop, slot, group, op, subslot, zero, sample, wb.wr_ack, wb.wr_busy} !== 15'd0) begin
            bad++;
            $display("FAIL async_reset: got %b expected all zero",
                     {cenop, slot, group, op, subslot, zero, sample, wb.wr_ack, wb.wr_busy});
        end
        wb.wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (slot !== 5'd0) begin
            bad++;
            $display("FAIL restart_hold: slot=%0d expected 0", slot);
        end
        @(negedge clk);
        total++;
        if (slot !== 5'd1) begin
            bad++;
            $display("FAIL restart_advance: slot=%0d expected 1", slot);
        end
        acks = 0;
        repeat (80) begin
            @(negedge clk);
            if (wb.wr_ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL restart_no_ack: acks=%0d expected 0", acks);
        end
    endtask

    task automatic test_div1;
        logic [15:0] pat;
        int exp_slot;
        int acks;
        pat      = 16'b1011_0010_1110_0111;
        exp_slot = 0;
        total++;
        if (slot1 !== 5'd0) begin
            bad++;
            $display("FAIL div1_start: slot=%0d expected 0", slot1);
        end
        for (int i = 0; i < 40 && exp_slot != 9; i++) begin
            cen1 = pat[i % 16];
            #1;
            total++;
            if (cenop1 !== cen1) begin
                bad++;
                $display("FAIL div1_cenop: cenop=%b expected %b", cenop1, cen1);
            end
            if (cen1) exp_slot = (exp_slot + 1) % 18;
            @(negedge clk);
            total++;
            if (slot1 !== 5'(exp_slot)) begin
                bad++;
                $display("FAIL div1_slot: slot=%0d expected %0d", slot1, exp_slot);
            end
        end
        cen1 = 1'b0;
        wb1.wr_slot = 5'd3;
        wb1.wr_req  = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (wb1.wr_busy !== 1'b1 || slot1 !== 5'd9) begin
            bad++;
            $display("FAIL div1_wait: busy=%b slot=%0d expected 1 and 9", wb1.wr_busy, slot1);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({slot1, group1, op1, subslot1, zero1, wb1.wr_busy, wb1.wr_ack} !== 14'd0) begin
            bad++;
            $display("FAIL div1_async_reset: got %b expected all zero",
                     {slot1, group1, op1, subslot1, zero1, wb1.wr_busy, wb1.wr_ack});
        end
        wb1.wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (slot1 !== 5'd0) begin
            bad++;
            $display("FAIL div1_stall: slot=%0d expected 0 with cen low", slot1);
        end
        cen1 = 1'b1;
        @(negedge clk);
        cen1 = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb1.wr_ack) acks++;
        end
        total++;
        if (slot1 !== 5'd1 || acks !== 0) begin
            bad++;
            $display("FAIL div1_restart: slot=%0d acks=%0d expected 1 and 0", slot1, acks);
        end
    endtask

    initial begin
        wb.wr_req   = 1'b0;
        wb.wr_slot  = 5'd0;
        wb1.wr_req  = 1'b0;
        wb1.wr_slot = 5'd0;
        test_reset;
        test_frame;
        test_write;
        test_same_edge;
        test_back_to_back;
        test_drop;
        test_bad_slot;
        test_reset_mid_write;
        test_div1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
